// File: rtl/apb_evt_cnt_reg.sv
// Read-to-clear event counters, one per channel, each with a sticky overflow flag.
// The channel picked by rd_sel is presented on a 32-bit APB read word.
module apb_evt_cnt_reg #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 10,
  parameter int SEL_W    = 1,
  parameter int SATURATE = 0,
  parameter int EDGE_DET = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [NUM_CH-1:0] evt,
  input  logic              clr_all,
  input  logic              read,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [31:0]       rdata,
  output logic              ovf_any
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] evt_q;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] rd_clr;

  // An out-of-range rd_sel matches no channel, so such a read clears nothing.
  always_comb begin
    hit    = '0;
    rd_clr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i]    = en & ((EDGE_DET != 0) ? (evt[i] & ~evt_q[i]) : evt[i]);
      rd_clr[i] = read & (rd_sel == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      evt_q <= '0;
      ovf   <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      evt_q <= evt;
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr_all) begin
          cnt[i] <= '0;
          ovf[i] <= 1'b0;
        end else if (rd_clr[i]) begin
          // an event coinciding with the read lands in the freshly cleared counter
          cnt[i] <= hit[i] ? CNT_ONE : '0;
          ovf[i] <= 1'b0;
        end else if (hit[i]) begin
          if (cnt[i] != CNT_MAX) begin
            cnt[i] <= cnt[i] + CNT_ONE;
          end else begin
            ovf[i] <= 1'b1;
            if (SATURATE == 0) cnt[i] <= '0;
          end
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rdata[31]        = ovf[i];
        rdata[CNT_W-1:0] = cnt[i];
      end
    end
  end

  assign ovf_any = |ovf;

endmodule

// File: tb/tb_apb_evt_cnt_reg.sv
// Bench for apb_evt_cnt_reg: four configurations driven in parallel and checked
// against an integer reference model of the counting rules.
module tb_apb_evt_cnt_reg;

  localparam int NI   = 4;
  localparam int MAXV = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, en, clr_all, read;
  logic [3:0] evt;
  logic [1:0] rd_sel;

  logic [31:0] rdata_w, rdata_s, rdata_e, rdata_n;
  logic        ova_w, ova_s, ova_e, ova_n;
  logic [31:0] rd_o  [NI];
  logic        ova_o [NI];

  assign rd_o[0] = rdata_w;  assign ova_o[0] = ova_w;
  assign rd_o[1] = rdata_s;  assign ova_o[1] = ova_s;
  assign rd_o[2] = rdata_e;  assign ova_o[2] = ova_e;
  assign rd_o[3] = rdata_n;  assign ova_o[3] = ova_n;

  // 0: wrap/level  1: saturate/level  2: wrap/edge  3: three channels, wrap/level
  apb_evt_cnt_reg #(.NUM_CH(4), .CNT_W(4), .SEL_W(2), .SATURATE(0), .EDGE_DET(0)) dut_w (
    .clk(clk), .rstn(rstn), .en(en), .evt(evt), .clr_all(clr_all), .read(read),
    .rd_sel(rd_sel), .rdata(rdata_w), .ovf_any(ova_w));
  apb_evt_cnt_reg #(.NUM_CH(4), .CNT_W(4), .SEL_W(2), .SATURATE(1), .EDGE_DET(0)) dut_s (
    .clk(clk), .rstn(rstn), .en(en), .evt(evt), .clr_all(clr_all), .read(read),
    .rd_sel(rd_sel), .rdata(rdata_s), .ovf_any(ova_s));
  apb_evt_cnt_reg #(.NUM_CH(4), .CNT_W(4), .SEL_W(2), .SATURATE(0), .EDGE_DET(1)) dut_e (
    .clk(clk), .rstn(rstn), .en(en), .evt(evt), .clr_all(clr_all), .read(read),
    .rd_sel(rd_sel), .rdata(rdata_e), .ovf_any(ova_e));
  apb_evt_cnt_reg #(.NUM_CH(3), .CNT_W(4), .SEL_W(2), .SATURATE(0), .EDGE_DET(0)) dut_n (
    .clk(clk), .rstn(rstn), .en(en), .evt(evt[2:0]), .clr_all(clr_all), .read(read),
    .rd_sel(rd_sel), .rdata(rdata_n), .ovf_any(ova_n));

  int c_nch [NI] = '{4, 4, 4, 3};
  int c_sat [NI] = '{0, 1, 0, 0};
  int c_edg [NI] = '{0, 0, 1, 0};

  int m_cnt [NI][4];
  bit m_ovf [NI][4];
  bit m_evq [NI][4];

  int nchecks = 0;
  int nerrors = 0;

  // Advance the model by one clock using the inputs as they stand before the edge.
  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < c_nch[k]; i++) begin
        if (!rstn) begin
          m_cnt[k][i] = 0;
          m_ovf[k][i] = 1'b0;
          m_evq[k][i] = 1'b0;
        end else begin
          bit h;
          h = en && ((c_edg[k] != 0) ? (evt[i] && !m_evq[k][i]) : evt[i]);
          m_evq[k][i] = evt[i];
          if (clr_all) begin
            m_cnt[k][i] = 0;
            m_ovf[k][i] = 1'b0;
          end else if (read && int'(rd_sel) == i) begin
            m_cnt[k][i] = h ? 1 : 0;
            m_ovf[k][i] = 1'b0;
          end else if (h) begin
            if (m_cnt[k][i] < MAXV) begin
              m_cnt[k][i] = m_cnt[k][i] + 1;
            end else begin
              m_ovf[k][i] = 1'b1;
              m_cnt[k][i] = (c_sat[k] != 0) ? MAXV : 0;
            end
          end
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rd(int k, int sel);
    if (sel >= c_nch[k]) return 32'h0;
    return 32'(m_cnt[k][sel]) | (m_ovf[k][sel] ? 32'h8000_0000 : 32'h0);
  endfunction

  function automatic logic exp_any(int k);
    for (int i = 0; i < c_nch[k]; i++) if (m_ovf[k][i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; en = 1'b1; evt = 4'hF; clr_all = 1'b0; read = 1'b0; rd_sel = 2'd0;
    tick();
    tick();
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      #1;
      for (int k = 0; k < NI; k++) begin
        nchecks++;
        if (rd_o[k] !== 32'h0) begin
          nerrors++;
          $display("FAIL reset_rdata inst%0d sel%0d: got %h want 0", k, s, rd_o[k]);
        end
      end
    end
    for (int k = 0; k < NI; k++) begin
      nchecks++;
      if (ova_o[k] !== 1'b0) begin
        nerrors++;
        $display("FAIL reset_ovf_any inst%0d: got %b want 0", k, ova_o[k]);
      end
    end
    rstn = 1'b1;
    evt  = 4'b0100;
    repeat (3) tick();
    evt    = 4'h0;
    rd_sel = 2'd2;
    #1;
    nchecks++;
    if (rd_o[0] !== 32'h3) begin
      nerrors++;
      $display("FAIL post_reset_count: got %h want 00000003", rd_o[0]);
    end
    for (int k = 0; k < NI; k++) begin
      nchecks++;
      if (rd_o[k] !== exp_rd(k, 2)) begin
        nerrors++;
        $display("FAIL post_reset_model inst%0d: got %h want %h", k, rd_o[k], exp_rd(k, 2));
      end
    end
  endtask

  task automatic test_overflow();
    clr_all = 1'b1; evt = 4'h0;
    tick();
    clr_all = 1'b0;
    evt     = 4'b0010;
    repeat (15) tick();
    rd_sel = 2'd1;
    #1;
    nchecks++;
    if (rd_o[0] !== 32'hF) begin
      nerrors++;
      $display("FAIL ch1_at_max: got %h want 0000000f", rd_o[0]);
    end
    tick();
    evt = 4'h0;
    #1;
    nchecks++;
    if (rd_o[0] !== 32'h8000_0000 || ova_o[0] !== 1'b1) begin
      nerrors++;
      $display("FAIL wrap_ovf: got %h/%b want 80000000/1", rd_o[0], ova_o[0]);
    end
    nchecks++;
    if (rd_o[1] !== 32'h8000_000F || ova_o[1] !== 1'b1) begin
      nerrors++;
      $display("FAIL sat_ovf: got %h/%b want 8000000f/1", rd_o[1], ova_o[1]);
    end
    nchecks++;
    if (rd_o[3] !== 32'h8000_0000) begin
      nerrors++;
      $display("FAIL nch3_wrap_ovf: got %h want 80000000", rd_o[3]);
    end
    read = 1'b1;
    #1;
    nchecks++;
    if (rd_o[0] !== 32'h8000_0000 || rd_o[1] !== 32'h8000_000F) begin
      nerrors++;
      $display("FAIL read_preclear: got %h %h want 80000000 8000000f", rd_o[0], rd_o[1]);
    end
    tick();
    read = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      nchecks++;
      if (rd_o[k] !== 32'h0 || ova_o[k] !== 1'b0) begin
        nerrors++;
        $display("FAIL read_clears_ovf inst%0d: got %h/%b want 0/0", k, rd_o[k], ova_o[k]);
      end
    end
  endtask

  task automatic test_read_coincident();
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    evt     = 4'b0001;
    repeat (5) tick();
    evt = 4'hF; read = 1'b1; rd_sel = 2'd0;
    #1;
    nchecks++;
    if (rd_o[0] !== 32'h5) begin
      nerrors++;
      $display("FAIL coincident_read_value: got %h want 00000005", rd_o[0]);
    end
    tick();
    read = 1'b0; evt = 4'h0;
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      #1;
      nchecks++;
      if (rd_o[0] !== 32'h1) begin
        nerrors++;
        $display("FAIL coincident_after sel%0d: got %h want 00000001", s, rd_o[0]);
      end
      for (int k = 0; k < NI; k++) begin
        nchecks++;
        if (rd_o[k] !== exp_rd(k, s)) begin
          nerrors++;
          $display("FAIL coincident_model inst%0d sel%0d: got %h want %h", k, s, rd_o[k], exp_rd(k, s));
        end
      end
    end
  endtask

  task automatic test_edge();
    clr_all = 1'b1; evt = 4'h0;
    tick();
    clr_all = 1'b0;
    evt = 4'b1000; repeat (6) tick();
    evt = 4'b0000; repeat (2) tick();
    evt = 4'b1000; repeat (3) tick();
    evt = 4'b0000; tick();
    rd_sel = 2'd3;
    #1;
    nchecks++;
    if (rd_o[2] !== 32'h2) begin
      nerrors++;
      $display("FAIL edge_two_pulses: got %h want 00000002", rd_o[2]);
    end
    nchecks++;
    if (rd_o[0] !== exp_rd(0, 3)) begin
      nerrors++;
      $display("FAIL edge_level_peer: got %h want %h", rd_o[0], exp_rd(0, 3));
    end
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    evt = 4'b1000; repeat (6) tick();
    evt = 4'b0000; repeat (2) tick();
    evt = 4'b1000; en = 1'b0;
    tick();
    en = 1'b1;
    repeat (2) tick();
    evt = 4'b0000; tick();
    nchecks++;
    if (rd_o[2] !== 32'h1) begin
      nerrors++;
      $display("FAIL edge_masked_by_en: got %h want 00000001", rd_o[2]);
    end
  endtask

  task automatic test_clr();
    clr_all = 1'b1; evt = 4'h0;
    tick();
    clr_all = 1'b0;
    evt = 4'b0111; tick();
    evt = 4'b0011; tick();
    evt = 4'b0001; tick();
    evt = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      #1;
      nchecks++;
      if (rd_o[0] !== 32'(3 - s)) begin
        nerrors++;
        $display("FAIL clr_setup sel%0d: got %h want %0d", s, rd_o[0], 3 - s);
      end
    end
    clr_all = 1'b1; evt = 4'hF;
    tick();
    clr_all = 1'b0; evt = 4'h0;
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      #1;
      for (int k = 0; k < NI; k++) begin
        nchecks++;
        if (rd_o[k] !== 32'h0) begin
          nerrors++;
          $display("FAIL clr_all inst%0d sel%0d: got %h want 0", k, s, rd_o[k]);
        end
      end
    end
  endtask

  task automatic test_nch3_oob();
    evt = 4'b0111;
    repeat (2) tick();
    evt = 4'h0; read = 1'b1; rd_sel = 2'd3;
    #1;
    nchecks++;
    if (rd_o[3] !== 32'h0) begin
      nerrors++;
      $display("FAIL oob_rdata: got %h want 0", rd_o[3]);
    end
    tick();
    read = 1'b0;
    for (int s = 0; s < 3; s++) begin
      rd_sel = 2'(s);
      #1;
      nchecks++;
      if (rd_o[3] !== 32'h2) begin
        nerrors++;
        $display("FAIL oob_no_clear sel%0d: got %h want 00000002", s, rd_o[3]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rstn    = ($urandom_range(0, 59) != 0);
      clr_all = ($urandom_range(0, 39) == 0);
      read    = ($urandom_range(0, 5) == 0);
      en      = ($urandom_range(0, 7) != 0);
      rd_sel  = 2'($urandom_range(0, 3));
      evt     = 4'($urandom_range(0, 15) | $urandom_range(0, 15));
      tick();
      for (int k = 0; k < NI; k++) begin
        nchecks++;
        if (rd_o[k] !== exp_rd(k, int'(rd_sel)) || ova_o[k] !== exp_any(k)) begin
          nerrors++;
          $display("FAIL random cyc%0d inst%0d sel%0d: got %h/%b want %h/%b", n, k, rd_sel,
                   rd_o[k], ova_o[k], exp_rd(k, int'(rd_sel)), exp_any(k));
        end
      end
    end
    read = 1'b0; clr_all = 1'b0; rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_read_coincident();
    test_edge();
    test_clr();
    test_nch3_oob();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
